// File: rtl/i2s_pkg.sv
// Constants and the stereo-pair type shared by the I2S receive path.
package i2s_pkg;

  localparam int FRAME_BITS           = 64;
  localparam int EOW_LEFT             = 17;
  localparam int EOW_RIGHT            = 49;
  localparam int CAPTURE_POSN_DEFAULT = 50;
  localparam int SAMPLE_W             = 16;
  localparam int POSN_W               = $clog2(FRAME_BITS);

  typedef struct packed {
    logic [SAMPLE_W-1:0] left;
    logic [SAMPLE_W-1:0] right;
  } stereo_t;

endpackage

// File: rtl/i2s_frame_fifo_if.sv
// Show-ahead stereo stream from the frame FIFO to the DSP pipeline.
interface i2s_frame_fifo_if;
  import i2s_pkg::*;

  logic                out_valid;
  logic                out_ready;
  logic [SAMPLE_W-1:0] out_left;
  logic [SAMPLE_W-1:0] out_right;

  modport master (output out_valid, output out_left, output out_right, input out_ready);
  modport slave  (input out_valid, input out_left, input out_right, output out_ready);

endinterface

// File: rtl/sync_fifo.sv
// Synchronous FIFO with a registered show-ahead head; a push into a full FIFO
// is accepted only when a pop frees a slot in the same cycle.
module sync_fifo #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 3
) (
  input  logic             ck,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic [ADDR_W:0]  level,
  output logic             dropped
);

  localparam int                DEPTH      = 2 ** ADDR_W;
  localparam logic [ADDR_W:0]   FULL_LEVEL = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W-1:0] PTR_ONE    = ADDR_W'(1);
  localparam logic [ADDR_W:0]   LVL_ONE    = (ADDR_W + 1)'(1);

  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]   level_q, level_d;
  logic              valid_q, valid_d;
  logic [WIDTH-1:0]  out_q, out_d;
  logic              pop;
  logic              push_ok;

  always_comb begin
    pop      = valid_q & pop_ready;
    push_ok  = push & ((level_q != FULL_LEVEL) | pop);
    dropped  = push & ~push_ok;
    rd_ptr_d = pop ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    wr_ptr_d = push_ok ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    level_d  = level_q;
    if (push_ok && !pop) begin
      level_d = level_q + LVL_ONE;
    end else if (pop && !push_ok) begin
      level_d = level_q - LVL_ONE;
    end
    valid_d = (level_d != '0);
    // The incoming word becomes the new head when it lands exactly where the read pointer is heading.
    out_d = out_q;
    if (push_ok && (wr_ptr_q == rd_ptr_d)) begin
      out_d = push_data;
    end else if (pop) begin
      out_d = mem_q[rd_ptr_d];
    end
  end

  always_ff @(posedge ck) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      level_q  <= '0;
      valid_q  <= 1'b0;
      out_q    <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      level_q  <= level_d;
      valid_q  <= valid_d;
      out_q    <= out_d;
    end
  end

  always_ff @(posedge ck) begin
    if (push_ok && !rst) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = out_q;
  assign level     = level_q;

endmodule

// File: rtl/i2s_frame_fifo.sv
// Snapshots one left/right pair per I2S frame into a FIFO and counts captures
// lost while the consumer stalls. The capture is registered once before the push.
module i2s_frame_fifo
  import i2s_pkg::*;
#(
  parameter int ADDR_W       = 3,
  parameter int CAPTURE_POSN = CAPTURE_POSN_DEFAULT,
  parameter int CNT_W        = 8
) (
  input  logic                ck,
  input  logic                rst,
  input  logic                en,
  input  logic                sample,
  input  logic [POSN_W-1:0]   frame_posn,
  input  logic [SAMPLE_W-1:0] left,
  input  logic [SAMPLE_W-1:0] right,
  i2s_frame_fifo_if.master    dout,
  output logic [ADDR_W:0]     level,
  output logic                overrun,
  output logic [CNT_W-1:0]    overrun_count
);

  localparam logic [POSN_W-1:0] CAP_POSN = POSN_W'(CAPTURE_POSN);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

  logic             cap_q, cap_d;
  stereo_t          pair_q, pair_d;
  logic             overrun_q, overrun_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             dropped;
  stereo_t          head;

  always_comb begin
    cap_d        = en & sample & (frame_posn == CAP_POSN);
    pair_d.left  = left;
    pair_d.right = right;
    overrun_d    = dropped;
    count_d      = count_q;
    if (dropped && (count_q != '1)) begin
      count_d = count_q + CNT_ONE;
    end
  end

  always_ff @(posedge ck) begin
    if (rst) begin
      cap_q     <= 1'b0;
      pair_q    <= '0;
      overrun_q <= 1'b0;
      count_q   <= '0;
    end else begin
      cap_q     <= cap_d;
      pair_q    <= pair_d;
      overrun_q <= overrun_d;
      count_q   <= count_d;
    end
  end

  sync_fifo #(
    .WIDTH ($bits(stereo_t)),
    .ADDR_W(ADDR_W)
  ) u_fifo (
    .ck       (ck),
    .rst      (rst),
    .push     (cap_q),
    .push_data(pair_q),
    .pop_ready(dout.out_ready),
    .out_valid(dout.out_valid),
    .out_data (head),
    .level    (level),
    .dropped  (dropped)
  );

  assign dout.out_left  = head.left;
  assign dout.out_right = head.right;
  assign overrun        = overrun_q;
  assign overrun_count  = count_q;

endmodule

// File: doc/i2s_frame_fifo.md
Name: i2s_frame_fifo

Overview:
Downstream stage of the I2S receiver. Snapshots the receiver's left/right 16-bit words once per 64-bit I2S frame, at a fixed frame position after both words are complete. Pushes each stereo pair into a small synchronous FIFO and presents it to the DSP pipeline on a valid/ready handshake. Reports overruns when the consumer stalls.

Parameters:
ADDR_W, 3, log2 of FIFO depth (depth = 8 stereo pairs)
CAPTURE_POSN, 50, frame_posn value at which the pair is captured (one sample slot after right-word latch at 49)
CNT_W, 8, width of saturating overrun counter

Ports:
ck  in  1  system clock
rst  in  1  synchronous active-high reset
en  in  1  capture enable; when low, no captures occur
sample  in  1  I2S bit-sample strobe, one ck wide
frame_posn  in  6  bit position within 64-bit I2S frame
left  in  16  left word from I2S receiver
right  in  16  right word from I2S receiver
out_valid  out  1  head-of-FIFO pair available
out_ready  in  1  consumer accepts the pair this cycle
out_left  out  16  head-of-FIFO left word
out_right  out  16  head-of-FIFO right word
level  out  ADDR_W+1  current FIFO occupancy, 0..2**ADDR_W
overrun  out  1  one-cycle pulse: a capture was dropped
overrun_count  out  CNT_W  saturating count of dropped captures

Behaviour:
- Reset (rst=1 at posedge ck): rd/wr pointers=0, level=0, out_valid=0, overrun=0, overrun_count=0. out_left/out_right=0. Memory contents are not cleared. Reset overrides every other event in the same cycle.
- Capture event: cap = en & sample & (frame_posn == CAPTURE_POSN). This occurs at most once per frame. The input words are {left,right} as sampled at that edge.
- Push: on cap, if level < depth, write the pair at wr_ptr, wr_ptr+1 (wraps mod depth), level+1.
- Pop: pop = out_valid & out_ready. rd_ptr+1 (wraps), level-1.
- Simultaneous push and pop: both are performed and level is unchanged. When full, a push is accepted if a pop occurs in the same cycle, and no overrun is flagged.
- Full without pop on cap: the new pair is dropped and stored data is untouched. overrun=1 for exactly one cycle. overrun_count increments and saturates at 2**CNT_W-1.
- Output is registered show-ahead. out_valid=1 whenever level>0. out_left/out_right always hold mem[rd_ptr] and are updated the cycle after rd_ptr or an empty-write changes.
- Latency: cap at edge N into an empty FIFO gives out_valid=1 with the correct data after edge N+1, i.e. one cycle.
- Empty with out_ready=1: no pop, and pointers and level are unchanged. out_left/out_right hold their last value.
- out_ready may be held high permanently. out_valid must not depend combinationally on out_ready.
- en deasserted mid-frame: it only suppresses future captures. Queued data still drains.
- Reset mid-drain: the FIFO is empty on the next cycle, and a capture coincident with rst is discarded.

Decomposition:
- Shared package i2s_pkg: FRAME_BITS=64, EOW_LEFT=17, EOW_RIGHT=49, CAPTURE_POSN_DEFAULT=50, SAMPLE_W=16, and a stereo-pair type {left,right} of 32 bits.
- One sub-module: sync_fifo (WIDTH=32, ADDR_W). It holds the pointers, level, memory and show-ahead output register.
- i2s_frame_fifo wraps sync_fifo with capture decode and overrun logic.

Test Plan:
- Single frame: left=16'h1234, right=16'hABCD, sample pulse at posn 50, out_ready=0 -> out_valid=1 one cycle later, out_left=1234, out_right=ABCD, level=1.
- Fill/overrun: 9 captures with distinct pairs n=0..8, out_ready=0 -> level=8, the 9th gives an overrun pulse and overrun_count=1. Draining yields pairs 0..7 in order; pair 8 is never seen.
- Full with simultaneous pop: FIFO at 8, cap coincides with out_ready=1 -> no overrun, level stays 8, and the new pair appears last in the drain order.
- Wrap-around: 20 frames with out_ready toggling 1 cycle on/1 off -> every pair is delivered in order across pointer wrap, and overrun_count stays 0.
- Gating: en=0 during 3 frames -> level unchanged. frame_posn=49 with sample, or posn 50 without sample -> no capture.
- Reset mid-operation: level=5, assert rst for 1 cycle coincident with a cap -> next cycle level=0, out_valid=0, overrun_count=0. The next capture is delivered normally.
